pipeline_out_fifo: RTL and testbench

- Synchronous FIFO placed directly downstream of the 4-stage global-stall pipeline.
- Accepts words from the pipeline's d_data/d_valid outputs.
- Drives the pipeline's d_ready from FIFO occupancy only, so the downstream consumer's ready never reaches the pipeline's global stall net combinationally.
- Absorbs downstream back-pressure and presents a standard valid/ready interface to the next consumer.

---
 rtl/pipeline_out_fifo.sv | 89 ++++++++
 tb/tb_pipeline_out_fifo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipeline_out_fifo.sv
// First-word-fall-through FIFO that decouples the global-stall pipeline from its consumer.
// Optional back-pressure counter enabled by defining PIPELINE_OUT_FIFO_STALL_CNT_EN.
module pipeline_out_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   u_data,
  input  logic                    u_valid,
  output logic                    u_ready,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic [15:0]             stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // The extra pointer MSB separates a full wrap from an empty FIFO.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  // u_ready depends only on registered pointers, keeping d_ready off the stall net.
  assign w_push = u_valid && !w_full;
  assign w_pop  = d_ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_addr] <= u_data;
    end
  end

  assign u_ready     = !w_full;
  assign d_valid     = !w_empty;
  assign d_data      = r_mem[w_rd_addr];
  assign count       = w_count;
  assign almost_full = (w_count >= PW'(AFULL_LEVEL));

`ifdef PIPELINE_OUT_FIFO_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where a word waits on the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (!w_empty && !d_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_out_fifo.sv
// Directed and random bench for pipeline_out_fifo with a queue-based reference model.
// Define PIPELINE_OUT_FIFO_STALL_CNT_EN for both files to exercise the saturating counter.
module tb_pipeline_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] u_data;
  logic          u_valid;
  logic          u_ready;
  logic [DW-1:0] d_data;
  logic          d_valid;
  logic          d_ready;
  logic [3:0]    count;
  logic          almost_full;
  logic [15:0]   stall_cnt;

  pipeline_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_data(u_data), .u_valid(u_valid), .u_ready(u_ready),
    .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
    .count(count), .almost_full(almost_full), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] q[$];
  int            stall_m  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    check({tag, "_u_ready"}, 32'(u_ready), 32'd1);
    check({tag, "_count"},   32'(count),   32'd0);
    check({tag, "_afull"},   32'(almost_full), 32'd0);
    check({tag, "_d_data"},  d_data,       32'd0);
    check({tag, "_stall"},   32'(stall_cnt), 32'd0);
  endtask

  // One cycle: drive inputs at the falling edge, compare against the model, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] data, input logic r);
    bit pop, push;
    @(negedge clk);
    u_valid = v;
    u_data  = data;
    d_ready = r;
    check("d_valid", 32'(d_valid), 32'(q.size() != 0));
    check("u_ready", 32'(u_ready), 32'(q.size() != DEPTH));
    check("count",   32'(count),   32'(q.size()));
    check("afull",   32'(almost_full), 32'(q.size() >= AFULL));
    check("stall",   32'(stall_cnt), 32'(stall_m));
    if (q.size() != 0) check("d_data", d_data, q[0]);
    pop  = (q.size() != 0) && r;
    push = v && (q.size() != DEPTH);
`ifdef PIPELINE_OUT_FIFO_STALL_CNT_EN
    if ((q.size() != 0) && !r && (stall_m < 65535)) stall_m++;
`endif
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(data);
  endtask

  initial begin
    rst_n   = 1'b0;
    u_valid = 1'b0;
    u_data  = '0;
    d_ready = 1'b0;

    // Reset, then idle
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0);

    // Fill with consumer stalled; a ninth word must be refused
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h10 + i, 1'b0);
    step(1'b1, 32'h18, 1'b0);
    step(1'b1, 32'h18, 1'b0);
    check("full_count",  32'(count),   32'd8);
    check("full_uready", 32'(u_ready), 32'd0);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain_seq", q.size() == 0 ? d_data : q[0], q.size() == 0 ? d_data : 32'h11 + i);
    end
    step(1'b0, '0, 1'b1);
    check("drain_empty", 32'(d_valid), 32'd0);

    // Streaming: count stays at 1 after the first word
    for (int i = 0; i < 100; i++) step(1'b1, 32'h1000 + i, 1'b1);
    check("stream_count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1);

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midrst");
        q.delete();
        stall_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Long back-pressure hold
    step(1'b1, 32'hABCD, 1'b0);
`ifdef PIPELINE_OUT_FIFO_STALL_CNT_EN
    for (int i = 0; i < 66000; i++) step(1'b0, '0, 1'b0);
    check("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    repeat (20) step(1'b0, '0, 1'b0);
    check("stall_hold", 32'(stall_cnt), 32'h0000FFFF);
`else
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b0);
    check("stall_off", 32'(stall_cnt), 32'd0);
`endif
    step(1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
